// File: rtl/instr_field_decoder.sv
// Registered ULM instruction decoder: splits the instruction register into
// control-unit, ALU and bus bundles, captured on clock edges where en is high.
module instr_field_decoder #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [31:0]       ir,
    input  logic              stat_reg_zf,
    output logic [1:0]        cu_op,
    output logic [7:0]        cu_exit_code,
    output logic [23:0]       cu_jmp_offset,
    output logic [1:0]        alu_op,
    output logic              alu_a_sel,
    output logic [3:0]        alu_s_reg,
    output logic [3:0]        alu_b_reg,
    output logic [3:0]        alu_a_reg,
    output logic [DATA_W-1:0] alu_a_imm,
    output logic [1:0]        bus_op,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_data_reg,
    output logic [3:0]        bus_addr_reg,
    output logic [16:0]       bus_addr_offset
);

    localparam logic [1:0] CU_NOP      = 2'd0;
    localparam logic [1:0] CU_HALT     = 2'd1;
    localparam logic [1:0] CU_REL_JMP  = 2'd2;
    localparam logic [1:0] ALU_NOP     = 2'd0;
    localparam logic [1:0] ALU_ADD     = 2'd1;
    localparam logic [1:0] ALU_SUB     = 2'd2;
    localparam logic [1:0] BUS_NOP     = 2'd0;
    localparam logic [1:0] BUS_FETCH   = 2'd1;
    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic       SEL_REG     = 1'b0;
    localparam logic       SEL_IMM     = 1'b1;

    logic [1:0]        nxt_cu_op;
    logic [1:0]        nxt_alu_op;
    logic              nxt_alu_a_sel;
    logic [3:0]        nxt_alu_b_reg;
    logic [3:0]        nxt_alu_a_reg;
    logic [DATA_W-1:0] nxt_alu_a_imm;
    logic [1:0]        nxt_bus_op;

    always_comb begin
        nxt_cu_op     = CU_NOP;
        nxt_alu_op    = ALU_NOP;
        nxt_alu_a_sel = SEL_REG;
        nxt_alu_b_reg = ir[19:16];
        nxt_alu_a_reg = ir[15:12];
        nxt_alu_a_imm = {{(DATA_W-16){1'b0}}, ir[15:0]};
        nxt_bus_op    = BUS_NOP;
        case (ir[31:24])
            8'h01: nxt_cu_op = CU_HALT;
            8'h02: nxt_cu_op = stat_reg_zf ? CU_NOP : CU_REL_JMP;
            8'h03: nxt_cu_op = stat_reg_zf ? CU_REL_JMP : CU_NOP;
            8'h04: nxt_cu_op = CU_REL_JMP;
            8'h10: begin
                // ldzwq: a 20-bit immediate added to r0 into the destination
                nxt_alu_op    = ALU_ADD;
                nxt_alu_a_sel = SEL_IMM;
                nxt_alu_b_reg = 4'd0;
                nxt_alu_a_reg = 4'd0;
                nxt_alu_a_imm = {{(DATA_W-20){1'b0}}, ir[19:0]};
            end
            8'h11: nxt_alu_op = ALU_ADD;
            8'h12: begin
                nxt_alu_op    = ALU_ADD;
                nxt_alu_a_sel = SEL_IMM;
            end
            8'h13: nxt_alu_op = ALU_SUB;
            8'h14: begin
                nxt_alu_op    = ALU_SUB;
                nxt_alu_a_sel = SEL_IMM;
            end
            8'h20: nxt_bus_op = BUS_FETCH;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cu_op           <= CU_NOP;
            cu_exit_code    <= '0;
            cu_jmp_offset   <= '0;
            alu_op          <= ALU_NOP;
            alu_a_sel       <= SEL_REG;
            alu_s_reg       <= '0;
            alu_b_reg       <= '0;
            alu_a_reg       <= '0;
            alu_a_imm       <= '0;
            bus_op          <= BUS_NOP;
            bus_size        <= SIZE_BYTE;
            bus_data_reg    <= '0;
            bus_addr_reg    <= '0;
            bus_addr_offset <= '0;
        end else if (en) begin
            cu_op           <= nxt_cu_op;
            cu_exit_code    <= ir[23:16];
            cu_jmp_offset   <= ir[23:0];
            alu_op          <= nxt_alu_op;
            alu_a_sel       <= nxt_alu_a_sel;
            alu_s_reg       <= ir[23:20];
            alu_b_reg       <= nxt_alu_b_reg;
            alu_a_reg       <= nxt_alu_a_reg;
            alu_a_imm       <= nxt_alu_a_imm;
            bus_op          <= nxt_bus_op;
            bus_size        <= SIZE_BYTE;
            bus_data_reg    <= ir[23:20];
            bus_addr_reg    <= ir[19:16];
            bus_addr_offset <= {1'b0, ir[15:0]};
        end
    end

endmodule

// File: tb/tb_instr_field_decoder.sv
// Bench for instr_field_decoder: hand-written vector table, enable/reset
// sequences and randomized instructions scored against a reference model.
module tb_instr_field_decoder;

    localparam int DATA_W = 64;

    typedef struct packed {
        logic [1:0]        cu_op;
        logic [7:0]        cu_exit_code;
        logic [23:0]       cu_jmp_offset;
        logic [1:0]        alu_op;
        logic              alu_a_sel;
        logic [3:0]        alu_s_reg;
        logic [3:0]        alu_b_reg;
        logic [3:0]        alu_a_reg;
        logic [DATA_W-1:0] alu_a_imm;
        logic [1:0]        bus_op;
        logic [1:0]        bus_size;
        logic [3:0]        bus_data_reg;
        logic [3:0]        bus_addr_reg;
        logic [16:0]       bus_addr_offset;
    } out_t;

    localparam int W = $bits(out_t);

    typedef struct {
        logic [31:0] ir;
        logic        zf;
        out_t        exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [31:0]       ir;
    logic              stat_reg_zf;
    logic [1:0]        cu_op;
    logic [7:0]        cu_exit_code;
    logic [23:0]       cu_jmp_offset;
    logic [1:0]        alu_op;
    logic              alu_a_sel;
    logic [3:0]        alu_s_reg;
    logic [3:0]        alu_b_reg;
    logic [3:0]        alu_a_reg;
    logic [DATA_W-1:0] alu_a_imm;
    logic [1:0]        bus_op;
    logic [1:0]        bus_size;
    logic [3:0]        bus_data_reg;
    logic [3:0]        bus_addr_reg;
    logic [16:0]       bus_addr_offset;

    out_t       dut_out;
    out_t       held;
    logic [W-1:0] exp_q[$];
    int         total;
    int         passed;
    vec_t       tbl[14];

    instr_field_decoder #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ir(ir), .stat_reg_zf(stat_reg_zf),
        .cu_op(cu_op), .cu_exit_code(cu_exit_code), .cu_jmp_offset(cu_jmp_offset),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_s_reg(alu_s_reg),
        .alu_b_reg(alu_b_reg), .alu_a_reg(alu_a_reg), .alu_a_imm(alu_a_imm),
        .bus_op(bus_op), .bus_size(bus_size), .bus_data_reg(bus_data_reg),
        .bus_addr_reg(bus_addr_reg), .bus_addr_offset(bus_addr_offset)
    );

    assign dut_out = '{cu_op, cu_exit_code, cu_jmp_offset, alu_op, alu_a_sel,
                       alu_s_reg, alu_b_reg, alu_a_reg, alu_a_imm, bus_op,
                       bus_size, bus_data_reg, bus_addr_reg, bus_addr_offset};

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: fields by shifting, ops by opcode ranges
    function automatic out_t model(input logic [31:0] i, input logic zf);
        out_t m;
        int   op;
        op = int'(i >> 24);
        m = '0;
        m.cu_exit_code    = 8'((i >> 16) % 256);
        m.cu_jmp_offset   = 24'(i % (1 << 24));
        m.alu_s_reg       = 4'((i >> 20) % 16);
        m.alu_b_reg       = 4'((i >> 16) % 16);
        m.alu_a_reg       = 4'((i >> 12) % 16);
        m.alu_a_imm       = DATA_W'(i % (1 << 16));
        m.bus_data_reg    = 4'((i >> 20) % 16);
        m.bus_addr_reg    = 4'((i >> 16) % 16);
        m.bus_addr_offset = 17'(i % (1 << 16));
        if (op == 1) m.cu_op = 2'd1;
        if (op == 4 || (op == 2 && !zf) || (op == 3 && zf)) m.cu_op = 2'd2;
        if (op == 'h10) begin
            m.alu_op = 2'd1; m.alu_a_sel = 1'b1;
            m.alu_b_reg = 4'd0; m.alu_a_reg = 4'd0;
            m.alu_a_imm = DATA_W'(i % (1 << 20));
        end
        if (op >= 'h11 && op <= 'h14) begin
            m.alu_op    = (op <= 'h12) ? 2'd1 : 2'd2;
            m.alu_a_sel = (op == 'h12 || op == 'h14);
        end
        if (op == 'h20) m.bus_op = 2'd1;
        return m;
    endfunction

    task automatic check(input string name, input out_t exp);
        total++;
        if (dut_out === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, dut_out, exp);
    endtask

    // Driver: apply one cycle, push expectation, then score it after the edge
    task automatic step(input logic [31:0] i, input logic z, input logic e, input string name);
        logic [W-1:0] e_val;
        @(negedge clk);
        ir = i; stat_reg_zf = z; en = e;
        if (e) held = model(i, z);
        exp_q.push_back(held);
        @(posedge clk);
        #1;
        e_val = exp_q.pop_front();
        check(name, out_t'(e_val));
    endtask

    initial begin
        total = 0; passed = 0; held = '0;
        rst_n = 1'b1; en = 1'b1; ir = 32'h04FFFFFF; stat_reg_zf = 1'b0;

        tbl[0]  = '{32'h04FFFFFF, 1'b0, '{2, 8'hFF, 24'hFFFFFF, 0, 0, 4'hF, 4'hF, 4'hF, 64'hFFFF, 0, 0, 4'hF, 4'hF, 17'h0FFFF}};
        tbl[1]  = '{32'h02000010, 1'b0, '{2, 8'h00, 24'h000010, 0, 0, 4'h0, 4'h0, 4'h0, 64'h0010, 0, 0, 4'h0, 4'h0, 17'h00010}};
        tbl[2]  = '{32'h02000010, 1'b1, '{0, 8'h00, 24'h000010, 0, 0, 4'h0, 4'h0, 4'h0, 64'h0010, 0, 0, 4'h0, 4'h0, 17'h00010}};
        tbl[3]  = '{32'h03000010, 1'b1, '{2, 8'h00, 24'h000010, 0, 0, 4'h0, 4'h0, 4'h0, 64'h0010, 0, 0, 4'h0, 4'h0, 17'h00010}};
        tbl[4]  = '{32'h03000010, 1'b0, '{0, 8'h00, 24'h000010, 0, 0, 4'h0, 4'h0, 4'h0, 64'h0010, 0, 0, 4'h0, 4'h0, 17'h00010}};
        tbl[5]  = '{32'h1035ABCD, 1'b0, '{0, 8'h35, 24'h35ABCD, 1, 1, 4'h3, 4'h0, 4'h0, 64'h5ABCD, 0, 0, 4'h3, 4'h5, 17'h0ABCD}};
        tbl[6]  = '{32'h13127000, 1'b0, '{0, 8'h12, 24'h127000, 2, 0, 4'h1, 4'h2, 4'h7, 64'h7000, 0, 0, 4'h1, 4'h2, 17'h07000}};
        tbl[7]  = '{32'h12458000, 1'b0, '{0, 8'h45, 24'h458000, 1, 1, 4'h4, 4'h5, 4'h8, 64'h8000, 0, 0, 4'h4, 4'h5, 17'h08000}};
        tbl[8]  = '{32'h2034FFFE, 1'b0, '{0, 8'h34, 24'h34FFFE, 0, 0, 4'h3, 4'h4, 4'hF, 64'hFFFE, 1, 0, 4'h3, 4'h4, 17'h0FFFE}};
        tbl[9]  = '{32'h01070000, 1'b1, '{1, 8'h07, 24'h070000, 0, 0, 4'h0, 4'h7, 4'h0, 64'h0000, 0, 0, 4'h0, 4'h7, 17'h00000}};
        tbl[10] = '{32'h30000000, 1'b0, '{0, 8'h00, 24'h000000, 0, 0, 4'h0, 4'h0, 4'h0, 64'h0000, 0, 0, 4'h0, 4'h0, 17'h00000}};
        tbl[11] = '{32'h14ABCDEF, 1'b0, '{0, 8'hAB, 24'hABCDEF, 2, 1, 4'hA, 4'hB, 4'hC, 64'hCDEF, 0, 0, 4'hA, 4'hB, 17'h0CDEF}};
        tbl[12] = '{32'h11FEDCBA, 1'b1, '{0, 8'hFE, 24'hFEDCBA, 1, 0, 4'hF, 4'hE, 4'hD, 64'hDCBA, 0, 0, 4'hF, 4'hE, 17'h0DCBA}};
        tbl[13] = '{32'h00FFFFFF, 1'b1, '{0, 8'hFF, 24'hFFFFFF, 0, 0, 4'hF, 4'hF, 4'hF, 64'hFFFF, 0, 0, 4'hF, 4'hF, 17'h0FFFF}};

        // Reset holds outputs at zero even with en high
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_zero", '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h04FFFFFF, 1'b0, 1'b1, "first_after_reset");
        check("first_after_reset_tbl", tbl[0].exp);

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].ir, tbl[k].zf, 1'b1, "tbl_model");
            check($sformatf("tbl_%0d", k), tbl[k].exp);
        end

        // Enable hold followed by HALT and an unhandled opcode
        step(32'h2034FFFE, 1'b0, 1'b1, "bus_fetch");
        step(32'h01070000, 1'b0, 1'b0, "hold_en0");
        check("hold_en0_tbl", tbl[8].exp);
        step(32'h01070000, 1'b0, 1'b1, "halt");
        check("halt_tbl", tbl[9].exp);
        step(32'h30000000, 1'b0, 1'b1, "op30_nop");
        check("op30_tbl", tbl[10].exp);

        // Asynchronous reset mid-stream, then reload of the current ir
        step(32'h1035ABCD, 1'b0, 1'b1, "pre_reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", '0);
        held = '0;
        @(posedge clk);
        #1 check("reset_hold", '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h13127000, 1'b0, 1'b1, "reload_after_reset");
        check("reload_tbl", tbl[6].exp);

        // Randomized stream with opcodes biased toward decoded ones
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri;
            logic [7:0]  ops[12];
            ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'h31};
            ri = $urandom;
            if ($urandom_range(0, 3) != 0) ri[31:24] = ops[$urandom_range(0, 11)];
            step(ri, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_field_decoder.md
Name: instr_field_decoder

Overview:
- Registered instruction decoder for the ULM core.
- Takes the 32-bit instruction register plus the status zero flag and produces three registered instruction bundles:
  - control-unit (jumps/halt)
  - ALU (add/sub/load-immediate)
  - bus (memory fetch)
- Sits between the instruction register and the CU/ALU/bus execution units. All outputs update only when `en` is high.

Parameters:
- DATA_W, 64, width of the zero-extended ALU immediate `alu_a_imm`.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; output registers load only when 1.
- ir  input  32  instruction word; opcode = ir[31:24].
- stat_reg_zf  input  1  zero flag from the status register.
- cu_op  output  2  0=NOP, 1=HALT, 2=REL_JMP.
- cu_exit_code  output  8  halt exit code.
- cu_jmp_offset  output  24  relative jump offset (raw field, unsigned as delivered).
- alu_op  output  2  0=NOP, 1=ADD, 2=SUB.
- alu_a_sel  output  1  0=register operand A, 1=immediate operand A.
- alu_s_reg  output  4  destination register.
- alu_b_reg  output  4  operand B register.
- alu_a_reg  output  4  operand A register.
- alu_a_imm  output  DATA_W  zero-extended immediate.
- bus_op  output  2  0=NOP, 1=FETCH.
- bus_size  output  2  0=BYTE, 1=WORD, 2=LONG, 3=QUAD.
- bus_data_reg  output  4  data register.
- bus_addr_reg  output  4  address base register.
- bus_addr_offset  output  17  address offset, {1'b0, ir[15:0]}.

Behaviour:
- Reset (rst_n=0, asynchronous): every output register clears to 0. This means cu_op=NOP, alu_op=NOP, alu_a_sel=REG, bus_op=NOP, bus_size=BYTE, and all fields 0. Reset wins over `en`.
- Latency: a combinational next-state is computed from `ir` and `stat_reg_zf`. It is captured on the rising clk edge where en=1. With en=0 all outputs hold their values.
- Default fields for any opcode:
  - cu_exit_code=ir[23:16], cu_jmp_offset=ir[23:0]
  - alu_s_reg=ir[23:20], alu_b_reg=ir[19:16], alu_a_reg=ir[15:12], alu_a_imm=zero-extended ir[15:0]
  - bus_data_reg=ir[23:20], bus_addr_reg=ir[19:16], bus_addr_offset={0,ir[15:0]}, bus_size=BYTE
  - all ops NOP, alu_a_sel=REG
- CU opcodes:
  - 0x01 HALT.
  - 0x02 jnz: REL_JMP if zf=0, else NOP.
  - 0x03 jz: REL_JMP if zf=1, else NOP.
  - 0x04 jmp: REL_JMP unconditionally.
  - zf is sampled in the same cycle as `ir`.
- ALU opcodes:
  - 0x10 ldzwq: ADD, a_sel=IMM, b_reg=0, a_reg=0, a_imm=zero-extended ir[19:0], s_reg=ir[23:20].
  - 0x11 addq reg: ADD, a_sel=REG.
  - 0x12 addq imm: ADD, a_sel=IMM.
  - 0x13 subq reg: SUB, a_sel=REG.
  - 0x14 subq imm: SUB, a_sel=IMM.
- Bus opcodes:
  - 0x20 movzbq: bus_op=FETCH, size=BYTE.
- Each opcode activates at most one group. The other groups output NOP with the default field extraction still applied.
- All other opcodes (including 0x00 and 0x30/0x31, which are handled elsewhere) produce NOP in all three groups.
- No wrap or arithmetic is performed. Immediates are always zero-extended, never sign-extended.
- Reset asserted mid-stream clears the outputs immediately. After release, the first en=1 edge loads the decode of the current `ir`.

Test Plan:
- Reset: rst_n=0 with ir=0x04FFFFFF, en=1 → all outputs 0. After release, the first en edge gives cu_op=2, cu_jmp_offset=0xFFFFFF.
- Conditional jumps:
  - ir=0x02000010, zf=0 → cu_op=2.
  - zf=1 → cu_op=0.
  - ir=0x03000010, zf=1 → cu_op=2.
- ldzwq: ir=0x1035ABCD → alu_op=1, a_sel=1, s_reg=3, b_reg=0, a_reg=0, a_imm=0x5ABCD, bus_op=0, cu_op=0.
- ALU reg/imm:
  - ir=0x13127000 → alu_op=2, a_sel=0, s_reg=1, b_reg=2, a_reg=7.
  - ir=0x12458000 → alu_op=1, a_sel=1, a_imm=0x8000 (zero-extended).
- Bus fetch: ir=0x2034FFFE → bus_op=1, size=0, data_reg=3, addr_reg=4, addr_offset=0x0FFFE.
- Enable hold and HALT:
  - ir=0x01070000 with en=0 → outputs unchanged.
  - Raise en → cu_op=1, cu_exit_code=0x07.
  - Then ir=0x30000000 → all ops NOP.
